// File: rtl/prog_encoder_if.sv
// Command handshake and instruction-memory write bus shared by the loader and its host.
interface prog_encoder_if #(
  parameter int IMEM_AW = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [2:0]         cmd_op;
  logic [1:0]         cmd_rd;
  logic [1:0]         cmd_rs1;
  logic [1:0]         cmd_rs2;
  logic [6:0]         cmd_alu;
  logic [15:0]        cmd_imm;
  logic               cmd_brz;
  logic               cmd_brpol;
  logic               cmd_last;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [15:0]        imem_wdata;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_alu, cmd_imm,
           cmd_brz, cmd_brpol, cmd_last,
    input  cmd_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_alu, cmd_imm,
           cmd_brz, cmd_brpol, cmd_last,
    output cmd_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/prog_encoder.sv
// Packs field-level commands into 16-bit instruction words and writes them to imem, holding the CPU meanwhile.
// Latency: command accepted in cycle N is written in N+1; one word per cycle. Optional checksum: PROG_ENC_CHECKSUM_EN.
// Backpressure: cmd_ready is high only while loading; an error or the last command drops it until the next start.
module prog_encoder #(
  parameter int                 IMEM_AW   = 8,
  parameter logic [IMEM_AW-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  prog_encoder_if.slave      bus,
  output logic               cpu_hold,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [IMEM_AW:0]   word_count
`ifdef PROG_ENC_CHECKSUM_EN
  ,
  output logic [15:0]        checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [IMEM_AW:0] FULL_COUNT = {1'b1, {IMEM_AW{1'b0}}};

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_OVFL    = 2'b11;

  state_t             state;
  state_t             stateNext;
  logic               accept;
  logic [15:0]        encWord;
  logic [1:0]         cmdErr;
  logic               weReg;
  logic [IMEM_AW-1:0] addrReg;
  logic [15:0]        wdataReg;
  logic [IMEM_AW-1:0] nextAddr;
  logic [IMEM_AW:0]   wordCnt;
  logic [1:0]         errCodeReg;
  logic               readyComb;
  logic               holdComb;
  logic               doneComb;
  logic               errComb;

  // start always wins over a simultaneous accept, so the command is dropped.
  assign accept = bus.cmd_valid && (state == LOAD) && !start;

  always_comb begin
    encWord = '0;
    cmdErr  = ERR_NONE;
    case (bus.cmd_op)
      3'b000: encWord = {3'b000, bus.cmd_rd, bus.cmd_rs1, bus.cmd_rs2, bus.cmd_alu};
      3'b001: begin
        encWord = {3'b001, bus.cmd_rd, bus.cmd_imm[10:0]};
        if (bus.cmd_imm[15:11] != 5'd0) cmdErr = ERR_RANGE;
      end
      3'b011: encWord = {3'b011, bus.cmd_rd, bus.cmd_rs1, 9'd0};
      3'b101: encWord = {3'b101, 2'b00, bus.cmd_rs1, bus.cmd_rs2, 7'd0};
      3'b110: begin
        encWord = {3'b110, bus.cmd_brz, bus.cmd_brpol, bus.cmd_imm[10:0]};
        // Offset must survive truncation to 11 bits: the sign bits above must all agree.
        if (!((&bus.cmd_imm[15:10]) || (~|bus.cmd_imm[15:10]))) cmdErr = ERR_RANGE;
      end
      3'b111: encWord = {3'b111, 2'b00, bus.cmd_rs1, 9'd0};
      default: cmdErr = ERR_ILLEGAL;
    endcase
    if (wordCnt == FULL_COUNT) cmdErr = ERR_OVFL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    readyComb = 1'b0;
    holdComb  = 1'b0;
    doneComb  = 1'b0;
    errComb   = 1'b0;
    case (state)
      IDLE: ;
      LOAD: begin
        readyComb = 1'b1;
        holdComb  = 1'b1;
        if (accept) begin
          if (cmdErr != ERR_NONE) stateNext = ERR;
          else if (bus.cmd_last)  stateNext = DONE;
        end
      end
      DONE: begin
        doneComb  = 1'b1;
        stateNext = IDLE;
      end
      ERR: begin
        holdComb = 1'b1;
        errComb  = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
    if (start) stateNext = LOAD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weReg      <= 1'b0;
      addrReg    <= '0;
      wdataReg   <= '0;
      nextAddr   <= BASE_ADDR;
      wordCnt    <= '0;
      errCodeReg <= ERR_NONE;
    end else begin
      weReg <= 1'b0;
      if (start) begin
        nextAddr   <= BASE_ADDR;
        wordCnt    <= '0;
        errCodeReg <= ERR_NONE;
      end else if (accept) begin
        if (cmdErr != ERR_NONE) begin
          errCodeReg <= cmdErr;
        end else begin
          weReg    <= 1'b1;
          addrReg  <= nextAddr;
          wdataReg <= encWord;
          nextAddr <= nextAddr + 1'b1;
          wordCnt  <= wordCnt + 1'b1;
        end
      end
    end
  end

`ifdef PROG_ENC_CHECKSUM_EN
  logic [15:0] sumReg;

  // Summed from the write register, so the total settles the cycle after the last write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sumReg <= '0;
    end else if (start) begin
      sumReg <= '0;
    end else if (weReg) begin
      sumReg <= sumReg + wdataReg;
    end
  end

  assign checksum = sumReg;
`endif

  assign bus.cmd_ready  = readyComb;
  assign bus.imem_we    = weReg;
  assign bus.imem_addr  = addrReg;
  assign bus.imem_wdata = wdataReg;
  assign cpu_hold       = holdComb;
  assign done           = doneComb;
  assign err            = errComb;
  assign err_code       = errCodeReg;
  assign word_count     = wordCnt;

endmodule

// File: tb/tb_prog_encoder.sv
// Randomized program loads checked cycle by cycle against a command-level model of the loader.
module tb_prog_encoder;
  localparam int             AW    = 3;
  localparam int             DEPTH = 8;
  localparam logic [AW-1:0]  BASE  = 3'd6;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  rd;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic [6:0]  alu;
    logic [15:0] imm;
    logic        brz;
    logic        brpol;
    logic        last;
  } cmd_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          cpuHold;
  logic          done;
  logic          err;
  logic [1:0]    errCode;
  logic [AW:0]   wordCount;
`ifdef PROG_ENC_CHECKSUM_EN
  logic [15:0]   checksum;
`endif

  int            checks = 0;
  int            errors = 0;
  int            mAddr;
  int            mCount;
  logic [15:0]   mSum;

  prog_encoder_if #(.IMEM_AW(AW)) bus ();

  prog_encoder #(.IMEM_AW(AW), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .cpu_hold   (cpuHold),
    .done       (done),
    .err        (err),
    .err_code   (errCode),
    .word_count (wordCount)
`ifdef PROG_ENC_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic cmd_t mk(input int op, input int rd, input int rs1, input int rs2,
                              input int alu, input int imm, input int brz, input int brpol,
                              input int last);
    cmd_t c;
    c.op = 3'(op); c.rd = 2'(rd); c.rs1 = 2'(rs1); c.rs2 = 2'(rs2); c.alu = 7'(alu);
    c.imm = 16'(imm); c.brz = 1'(brz); c.brpol = 1'(brpol); c.last = 1'(last);
    return c;
  endfunction

  // Instruction word built from field weights: op at 2^13, rd at 2^11, rs1 at 2^9, rs2 at 2^7.
  function automatic logic [15:0] modelWord(input cmd_t c);
    int v;
    case (int'(c.op))
      0: v = int'(c.rd) * 2048 + int'(c.rs1) * 512 + int'(c.rs2) * 128 + int'(c.alu);
      1: v = 8192 + int'(c.rd) * 2048 + int'(c.imm) % 2048;
      3: v = 3 * 8192 + int'(c.rd) * 2048 + int'(c.rs1) * 512;
      5: v = 5 * 8192 + int'(c.rs1) * 512 + int'(c.rs2) * 128;
      6: v = 6 * 8192 + int'(c.brz) * 4096 + int'(c.brpol) * 2048 + int'(c.imm) % 2048;
      7: v = 7 * 8192 + int'(c.rs1) * 512;
      default: v = 0;
    endcase
    return 16'(v);
  endfunction

  function automatic int modelCode(input cmd_t c, input int count);
    int s;
    s = int'($signed(c.imm));
    if (count == DEPTH) return 3;
    if (c.op == 3'd2 || c.op == 3'd4) return 1;
    if (c.op == 3'd1 && int'(c.imm) > 2047) return 2;
    if (c.op == 3'd6 && (s < -1024 || s > 1023)) return 2;
    return 0;
  endfunction

  function automatic cmd_t randCmd();
    cmd_t c;
    int   legal[6] = '{0, 1, 3, 5, 6, 7};
    c = mk(legal[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 127), 0, $urandom_range(0, 1),
           $urandom_range(0, 1), 0);
    if ($urandom_range(0, 15) == 0) c.op = ($urandom_range(0, 1) == 1) ? 3'd2 : 3'd4;
    if (c.op == 3'd1) c.imm = 16'($urandom_range(0, 2047));
    else              c.imm = 16'($urandom_range(0, 2047) - 1024);
    if ($urandom_range(0, 9) == 0) c.imm = 16'($urandom);
    return c;
  endfunction

  task automatic drive(input cmd_t c);
    bus.cmd_op = c.op; bus.cmd_rd = c.rd; bus.cmd_rs1 = c.rs1; bus.cmd_rs2 = c.rs2;
    bus.cmd_alu = c.alu; bus.cmd_imm = c.imm; bus.cmd_brz = c.brz; bus.cmd_brpol = c.brpol;
    bus.cmd_last = c.last;
  endtask

  task automatic runProg(input cmd_t prog[$], input int injectAt);
    int          code;
    int          endCode;
    bit          stop;
    bit          finished;
    logic [15:0] w;
    stop = 0; finished = 0; endCode = 0;
    @(negedge clk);
    start = 1'b1; bus.cmd_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    mAddr = int'(BASE); mCount = 0; mSum = '0;
    chk("ld_rdy", 32'(bus.cmd_ready), 1);
    chk("ld_hold", 32'(cpuHold), 1);
    chk("ld_err", 32'(err), 0);
    chk("ld_code", 32'(errCode), 0);
    chk("ld_cnt", 32'(wordCount), 0);
    for (int i = 0; i < prog.size() && !stop; i++) begin
      drive(prog[i]);
      bus.cmd_valid = 1'b1;
      chk("rdy", 32'(bus.cmd_ready), 1);
      if (i == injectAt) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mAddr = int'(BASE); mCount = 0; mSum = '0;
        chk("rs_we", 32'(bus.imem_we), 0);
        chk("rs_cnt", 32'(wordCount), 0);
        chk("rs_rdy", 32'(bus.cmd_ready), 1);
        continue;
      end
      @(negedge clk);
      code = modelCode(prog[i], mCount);
      if (code != 0) begin
        chk("e_we", 32'(bus.imem_we), 0);
        chk("e_err", 32'(err), 1);
        chk("e_code", 32'(errCode), 32'(code));
        chk("e_rdy", 32'(bus.cmd_ready), 0);
        chk("e_hold", 32'(cpuHold), 1);
        endCode = code; stop = 1;
      end else begin
        w = modelWord(prog[i]);
        mCount++;
        mSum = mSum + w;
        chk("we", 32'(bus.imem_we), 1);
        chk("addr", 32'(bus.imem_addr), 32'(mAddr));
        chk("wdata", 32'(bus.imem_wdata), 32'(w));
        chk("cnt", 32'(wordCount), 32'(mCount));
        chk("done", 32'(done), 32'(prog[i].last));
        mAddr = (mAddr + 1) % DEPTH;
        if (prog[i].last) begin
          chk("d_hold", 32'(cpuHold), 0);
          stop = 1; finished = 1;
        end
      end
    end
    if (endCode != 0) begin
      // Commands offered while in error must be ignored.
      repeat (2) begin
        @(negedge clk);
        chk("x_we", 32'(bus.imem_we), 0);
        chk("x_err", 32'(err), 1);
        chk("x_code", 32'(errCode), 32'(endCode));
        chk("x_cnt", 32'(wordCount), 32'(mCount));
        chk("x_rdy", 32'(bus.cmd_ready), 0);
      end
    end else if (finished) begin
      @(negedge clk);
      chk("i_done", 32'(done), 0);
      chk("i_hold", 32'(cpuHold), 0);
      chk("i_rdy", 32'(bus.cmd_ready), 0);
      chk("i_we", 32'(bus.imem_we), 0);
`ifdef PROG_ENC_CHECKSUM_EN
      chk("csum", 32'(checksum), 32'(mSum));
`endif
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_we"}, 32'(bus.imem_we), 0);
    chk({tag, "_addr"}, 32'(bus.imem_addr), 0);
    chk({tag, "_wdata"}, 32'(bus.imem_wdata), 0);
    chk({tag, "_rdy"}, 32'(bus.cmd_ready), 0);
    chk({tag, "_hold"}, 32'(cpuHold), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_code"}, 32'(errCode), 0);
    chk({tag, "_cnt"}, 32'(wordCount), 0);
  endtask

  task automatic midReset();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drive(mk(0, 1, 2, 3, 5, 0, 0, 0, 0));
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("mr_we_pre", 32'(bus.imem_we), 1);
    #2 reset = 1'b1;
    #1 checkAllZero("mr");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_idle_rdy", 32'(bus.cmd_ready), 0);
    chk("mr_idle_hold", 32'(cpuHold), 0);
  endtask

  initial begin
    cmd_t prog[$];
    int   n;
    bus.cmd_valid = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    #3 checkAllZero("rst");
    @(negedge clk);
    reset = 1'b0;

    prog = '{mk(0, 1, 2, 3, 5, 0, 0, 0, 1)};
    runProg(prog, -1);
    prog = '{mk(1, 2, 0, 0, 0, 16'h07FF, 0, 0, 0), mk(1, 2, 0, 0, 0, 16'h0800, 0, 0, 0)};
    runProg(prog, -1);
    prog = '{mk(6, 0, 0, 0, 0, 16'hFFFD, 1, 1, 0), mk(6, 0, 0, 0, 0, 16'hFBFF, 1, 1, 0)};
    runProg(prog, -1);
    prog = '{mk(5, 0, 1, 2, 0, 0, 0, 0, 0), mk(3, 3, 1, 0, 0, 0, 0, 0, 0),
             mk(7, 0, 2, 0, 0, 0, 0, 0, 1)};
    runProg(prog, -1);
    prog = '{mk(4, 0, 0, 0, 0, 0, 0, 0, 0)};
    runProg(prog, -1);
    prog = '{};
    for (int i = 0; i < 10; i++) prog.push_back(mk(0, 1, 1, 1, i, 0, 0, 0, 0));
    runProg(prog, -1);

    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(1, 12);
      prog = '{};
      for (int i = 0; i < n; i++) prog.push_back(randCmd());
      prog[n - 1].last = 1'b1;
      runProg(prog, (n >= 3 && $urandom_range(0, 4) == 0) ? n / 2 : -1);
    end

    midReset();
    prog = '{mk(0, 1, 2, 3, 5, 0, 0, 0, 0), mk(5, 0, 1, 2, 0, 0, 0, 0, 1)};
    runProg(prog, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
